// File: rtl/demux_feeder_if.sv
// rtl/demux_feeder_if.sv - input stream and demux-facing handshake bundle for demux_feeder
interface demux_feeder_if;
  logic [1:0] in_data;
  logic       in_dest;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] mux_data;
  logic       mux_sel;
  logic       mux_valid;
  logic       lane_b_ready;
  logic       lane_c_ready;

  modport slave (
    input  in_data, in_dest, in_valid, lane_b_ready, lane_c_ready,
    output in_ready, mux_data, mux_sel, mux_valid
  );

  modport master (
    output in_data, in_dest, in_valid, lane_b_ready, lane_c_ready,
    input  in_ready, mux_data, mux_sel, mux_valid
  );
endinterface

// File: rtl/demux_feeder.sv
// rtl/demux_feeder.sv - FIFO-buffered feeder driving a 2-way demux data/select pair
module demux_feeder #(
  parameter int DEPTH       = 4,
  parameter int STALL_LIMIT = 16,
  parameter int CNT_W       = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     steer_mode,
  demux_feeder_if.slave            bus,
  output logic [$clog2(DEPTH):0]   fill,
  output logic [CNT_W-1:0]         count_b,
  output logic [CNT_W-1:0]         count_c,
  output logic                     stall_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STALL_LIMIT + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] LOADED  = 2'd1;
  localparam logic [1:0] BLOCKED = 2'd2;

  logic [2:0]       mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      fill_q, fill_d;
  logic [1:0]       state_q, state_d;
  logic [1:0]       data_q, data_d;
  logic             sel_q, sel_d;
  logic             mode_q, mode_d;
  logic             alt_q, alt_d;
  logic [CNT_W-1:0] cnt_b_q, cnt_b_d, cnt_c_q, cnt_c_d;
  logic [SW-1:0]    stall_cnt_q, stall_cnt_d;
  logic             stall_err_q, stall_err_d;
  logic             rdy_en_q;

  logic       mux_valid, xfer, push, load, alt_eff;
  logic [2:0] head;

  assign mux_valid = (state_q != IDLE);
  assign xfer      = mux_valid && (sel_q ? bus.lane_c_ready : bus.lane_b_ready);
  assign bus.in_ready = rdy_en_q && (fill_q != (AW+1)'(DEPTH));
  assign push      = bus.in_valid && bus.in_ready;
  assign load      = (!mux_valid || xfer) && (fill_q != '0);
  assign head      = mem_q[rd_ptr_q];
  // The symbol leaving this edge has already flipped the pointer for its successor.
  assign alt_eff   = alt_q ^ (xfer && mode_q);

  always_comb begin
    wr_ptr_d    = wr_ptr_q + AW'(push);
    rd_ptr_d    = rd_ptr_q + AW'(load);
    fill_d      = fill_q + (AW+1)'(push) - (AW+1)'(load);
    state_d     = state_q;
    data_d      = data_q;
    sel_d       = sel_q;
    mode_d      = mode_q;
    alt_d       = alt_eff;
    cnt_b_d     = cnt_b_q;
    cnt_c_d     = cnt_c_q;
    stall_cnt_d = stall_cnt_q;
    if (load) begin
      data_d  = head[1:0];
      sel_d   = steer_mode ? alt_eff : head[2];
      mode_d  = steer_mode;
      state_d = LOADED;
    end else if (xfer) begin
      data_d  = 2'b00;
      state_d = IDLE;
    end else if (mux_valid) begin
      state_d = BLOCKED;
    end
    if (xfer && !sel_q) cnt_b_d = cnt_b_q + CNT_W'(1);
    if (xfer && sel_q)  cnt_c_d = cnt_c_q + CNT_W'(1);
    if (xfer)
      stall_cnt_d = '0;
    else if (mux_valid && stall_cnt_q != SW'(STALL_LIMIT))
      stall_cnt_d = stall_cnt_q + SW'(1);
    stall_err_d = stall_err_q || (stall_cnt_d == SW'(STALL_LIMIT));
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.in_dest, bus.in_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      state_q     <= IDLE;
      data_q      <= 2'b00;
      sel_q       <= 1'b0;
      mode_q      <= 1'b0;
      alt_q       <= 1'b0;
      cnt_b_q     <= '0;
      cnt_c_q     <= '0;
      stall_cnt_q <= '0;
      stall_err_q <= 1'b0;
      rdy_en_q    <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      state_q     <= state_d;
      data_q      <= data_d;
      sel_q       <= sel_d;
      mode_q      <= mode_d;
      alt_q       <= alt_d;
      cnt_b_q     <= cnt_b_d;
      cnt_c_q     <= cnt_c_d;
      stall_cnt_q <= stall_cnt_d;
      stall_err_q <= stall_err_d;
      rdy_en_q    <= 1'b1;
    end
  end

  assign bus.mux_data  = data_q;
  assign bus.mux_sel   = sel_q;
  assign bus.mux_valid = mux_valid;
  assign fill          = fill_q;
  assign count_b       = cnt_b_q;
  assign count_c       = cnt_c_q;
  assign stall_err     = stall_err_q;
endmodule

// File: tb/tb_demux_feeder.sv
// tb/tb_demux_feeder.sv - scoreboard bench for demux_feeder against an occupancy-level model
module tb_demux_feeder;
  localparam int DEPTH = 4;
  localparam int LIMIT = 16;

  logic       clk = 0;
  logic       rst_n = 0;
  logic       steer_mode = 0;
  logic [2:0] fill;
  logic [7:0] count_b, count_c;
  logic       stall_err;

  demux_feeder_if bus();

  demux_feeder #(.DEPTH(DEPTH), .STALL_LIMIT(LIMIT), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .steer_mode(steer_mode), .bus(bus),
    .fill(fill), .count_b(count_b), .count_c(count_c), .stall_err(stall_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct { logic [1:0] d; logic dest; } sym_t;
  sym_t exp_q[$];
  int   m_f, m_cb, m_cc, m_scnt;
  bit   m_v, m_err, m_alt, m_rdy_en;

  // Model: every accepted symbol is in the system, in order; the oldest one sits on mux_* when visible.
  always @(negedge clk) begin
    bit push, xfer, pop, exp_sel;
    if (!rst_n) begin
      m_f = 0; m_v = 0; m_cb = 0; m_cc = 0; m_scnt = 0;
      m_err = 0; m_alt = 0; m_rdy_en = 0;
      exp_q.delete();
    end else begin
      exp_sel = 0;
      if (m_v && exp_q.size() > 0) exp_sel = steer_mode ? m_alt : exp_q[0].dest;
      check("mux_valid", bus.mux_valid, m_v);
      check("fill", fill, m_f);
      check("in_ready", bus.in_ready, m_rdy_en && (m_f != DEPTH));
      check("count_b", count_b, m_cb);
      check("count_c", count_c, m_cc);
      check("stall_err", stall_err, m_err);
      if (m_v && exp_q.size() > 0) begin
        check("mux_data", bus.mux_data, exp_q[0].d);
        check("mux_sel", bus.mux_sel, exp_sel);
      end else if (!m_v) begin
        check("idle_data", bus.mux_data, 0);
      end
      push = bus.in_valid && m_rdy_en && (m_f != DEPTH);
      xfer = m_v && (exp_sel ? bus.lane_c_ready : bus.lane_b_ready);
      if (xfer) begin
        void'(exp_q.pop_front());
        if (exp_sel) m_cc = (m_cc + 1) % 256; else m_cb = (m_cb + 1) % 256;
        if (steer_mode) m_alt = !m_alt;
        m_scnt = 0;
      end else if (m_v && m_scnt < LIMIT) begin
        m_scnt++;
      end
      if (m_scnt == LIMIT) m_err = 1;
      if (push) exp_q.push_back('{d: bus.in_data, dest: bus.in_dest});
      pop = (!m_v || xfer) && (m_f > 0);
      m_f = m_f + int'(push) - int'(pop);
      m_v = pop || (m_v && !xfer);
      m_rdy_en = 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_sym(input logic [1:0] d, input logic dst);
    int n = 0;
    bus.in_data = d; bus.in_dest = dst; bus.in_valid = 1;
    while (!bus.in_ready && n < 200) begin tick(); n++; end
    check("push_wait", int'(n < 200), 1);
    tick();
    bus.in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    bus.lane_b_ready = 1; bus.lane_c_ready = 1;
    while ((fill != 0 || bus.mux_valid) && n < 500) begin tick(); n++; end
    check("drain_wait", int'(n < 500), 1);
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    bus.in_data = 0; bus.in_dest = 0; bus.in_valid = 0;
    bus.lane_b_ready = 0; bus.lane_c_ready = 0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_mux_valid", bus.mux_valid, 0);
    check("rst_fill", fill, 0);
    check("rst_stall", stall_err, 0);
    rst_n = 1;
    tick();
    check("ready_after_rst", bus.in_ready, 1);

    // directed order/lane test
    bus.lane_b_ready = 1; bus.lane_c_ready = 1;
    push_sym(2'b01, 0); push_sym(2'b10, 1); push_sym(2'b11, 0);
    drain();
    check("p1_count_b", count_b, 2);
    check("p1_count_c", count_c, 1);

    // backpressure fills the FIFO; the sixth push must wait
    bus.lane_b_ready = 0; bus.lane_c_ready = 0;
    for (int i = 0; i < 5; i++) push_sym(2'(i), 0);
    check("p2_fill_full", fill, 4);
    check("p2_ready_low", bus.in_ready, 0);
    bus.in_data = 2'b11; bus.in_dest = 0; bus.in_valid = 1;
    repeat (3) tick();
    check("p2_still_full", fill, 4);
    bus.lane_b_ready = 1;
    while (!bus.in_ready) tick();
    tick();
    bus.in_valid = 0;
    drain();
    check("p2_count_b", count_b, 8);

    // alternating steer ignores in_dest
    steer_mode = 1;
    for (int i = 0; i < 4; i++) push_sym(2'(i), 1);
    drain();
    check("p3_count_b", count_b, 10);
    check("p3_count_c", count_c, 3);
    steer_mode = 0;

    // stuck lane C while B is ready
    bus.lane_b_ready = 1; bus.lane_c_ready = 0;
    push_sym(2'b10, 1);
    repeat (20) tick();
    check("p4_stall_set", stall_err, 1);
    check("p4_no_xfer_c", count_c, 3);
    drain();
    check("p4_stall_sticky", stall_err, 1);

    // randomized traffic
    for (int blk = 0; blk < 4; blk++) begin
      steer_mode = 1'($urandom);
      for (int c = 0; c < 80; c++) begin
        bus.in_valid = 1'($urandom);
        bus.in_data = 2'($urandom);
        bus.in_dest = 1'($urandom);
        bus.lane_b_ready = ($urandom_range(0, 3) != 0);
        bus.lane_c_ready = ($urandom_range(0, 3) != 0);
        tick();
      end
      bus.in_valid = 0;
      drain();
    end
    steer_mode = 0;

    // asynchronous reset mid-stream
    bus.lane_b_ready = 0; bus.lane_c_ready = 0;
    for (int i = 0; i < 4; i++) push_sym(2'(3 - i), 0);
    check("p5_fill3", fill, 3);
    #1;
    rst_n = 0;
    #1;
    check("arst_mux_valid", bus.mux_valid, 0);
    check("arst_fill", fill, 0);
    check("arst_count_b", count_b, 0);
    check("arst_count_c", count_c, 0);
    check("arst_stall", stall_err, 0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1;
    tick();

    // 256 lane-B transfers wrap the counter
    bus.lane_b_ready = 1; bus.lane_c_ready = 1;
    for (int i = 0; i < 256; i++) push_sym(2'($urandom), 0);
    drain();
    check("wrap_count_b", count_b, 0);
    check("wrap_count_c", count_c, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
